// File: rtl/econ_input_framer_if.sv
// Sample-in / frame-out handshake bundle between the sensor stream, the framer
// and the econV0 input_48_rsc port.
interface econ_input_framer_if #(
  parameter int SAMPLE_W  = 18,
  parameter int N_SAMPLES = 48
);
  logic [SAMPLE_W-1:0]           in_dat;
  logic                          in_sof;
  logic                          in_vld;
  logic                          in_rdy;
  logic [SAMPLE_W*N_SAMPLES-1:0] out_dat;
  logic                          out_vld;
  logic                          out_rdy;
  logic [7:0]                    frame_err_cnt;

  modport master (
    output in_dat, in_sof, in_vld, out_rdy,
    input  in_rdy, out_dat, out_vld, frame_err_cnt
  );

  modport slave (
    input  in_dat, in_sof, in_vld, out_rdy,
    output in_rdy, out_dat, out_vld, frame_err_cnt
  );
endinterface

// File: rtl/econ_input_framer.sv
// Packs N_SAMPLES serial samples (sof-marked) into one frame word, with a
// one-frame holding register in front of the econV0 valid/ready input.
module econ_input_framer #(
  parameter int SAMPLE_W  = 18,
  parameter int N_SAMPLES = 48
) (
  input logic               clk,
  input logic               rst,
  econ_input_framer_if.slave bus
);
  localparam int FRAME_W = SAMPLE_W * N_SAMPLES;
  localparam int IDX_W   = $clog2(N_SAMPLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [FRAME_W-1:0] coll_p0;
  logic [FRAME_W-1:0] coll_wr;
  logic [IDX_W-1:0]   idx_p0;
  logic               synced_p0;
  logic [FRAME_W-1:0] hold_p1;
  logic               vld_p1;
  logic [7:0]         err_cnt;
  logic               accept;
  logic               collecting;
  logic               sync_err;
  logic               frame_done;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stall only the final sample while the holding register is still occupied,
  // so a load can never collide with a drain.
  assign bus.in_rdy = !((idx_p0 == LAST_IDX) && vld_p1);

  assign accept     = bus.in_vld && bus.in_rdy;
  assign collecting = synced_p0 && (idx_p0 != '0);
  assign sync_err   = accept && (bus.in_sof ? (idx_p0 != '0) : !collecting);
  assign frame_done = accept && !bus.in_sof && collecting && (idx_p0 == LAST_IDX);

  always_comb begin
    coll_wr = coll_p0;
    coll_wr[SAMPLE_W*idx_p0 +: SAMPLE_W] = bus.in_dat;
  end

  // Stage p0: sample collector
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coll_p0   <= '0;
      idx_p0    <= '0;
      synced_p0 <= 1'b0;
    end else if (accept) begin
      if (bus.in_sof) begin
        coll_p0[SAMPLE_W-1:0] <= bus.in_dat;
        idx_p0                <= IDX_ONE;
        synced_p0             <= 1'b1;
      end else if (collecting) begin
        coll_p0 <= coll_wr;
        idx_p0  <= frame_done ? '0 : idx_p0 + IDX_ONE;
      end
    end
  end

  // Stage p1: frame holding register and sync-error counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_p1 <= '0;
      vld_p1  <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (frame_done) begin
        hold_p1 <= coll_wr;
        vld_p1  <= 1'b1;
      end else if (vld_p1 && bus.out_rdy) begin
        vld_p1 <= 1'b0;
      end
      if (sync_err) begin
        err_cnt <= sat_inc(err_cnt);
      end
    end
  end

  assign bus.out_dat       = hold_p1;
  assign bus.out_vld       = vld_p1;
  assign bus.frame_err_cnt = err_cnt;
endmodule

// File: tb/tb_econ_input_framer.sv
// Testbench for econ_input_framer: directed scenarios plus random traffic
// against a queue-based frame model.
module tb_econ_input_framer;
  localparam int SW = 18;
  localparam int NS = 48;
  localparam int FW = SW * NS;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  econ_input_framer_if #(.SAMPLE_W(SW), .N_SAMPLES(NS)) bus ();

  econ_input_framer #(.SAMPLE_W(SW), .N_SAMPLES(NS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: current partial frame as a sample queue, plus held frame
  logic [SW-1:0] part[$];
  logic [FW-1:0] m_hold;
  logic          m_vld;
  int            m_err;
  logic          last_acc;

  task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic m_rdy();
    return !((part.size() == NS - 1) && m_vld);
  endfunction

  task automatic model_reset();
    part.delete();
    m_hold = '0;
    m_vld  = 1'b0;
    m_err  = 0;
  endtask

  task automatic model_edge();
    logic drain;
    drain    = m_vld && bus.out_rdy;
    last_acc = bus.in_vld && m_rdy();
    if (drain) m_vld = 1'b0;
    if (last_acc) begin
      if (bus.in_sof) begin
        if (part.size() != 0 && m_err < 255) m_err++;
        part.delete();
        part.push_back(bus.in_dat);
      end else if (part.size() == 0) begin
        if (m_err < 255) m_err++;
      end else begin
        part.push_back(bus.in_dat);
        if (part.size() == NS) begin
          for (int i = 0; i < NS; i++) m_hold[SW*i +: SW] = part[i];
          m_vld = 1'b1;
          part.delete();
        end
      end
    end
  endtask

  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic step(input logic v, input logic s, input logic [SW-1:0] d, input logic r);
    bus.in_vld  = v;
    bus.in_sof  = s;
    bus.in_dat  = d;
    bus.out_rdy = r;
    #1;
    chk("in_rdy", FW'(bus.in_rdy), FW'(m_rdy()));
    model_edge();
    @(posedge clk);
    @(negedge clk);
    chk("out_vld", FW'(bus.out_vld), FW'(m_vld));
    chk("out_dat", bus.out_dat, m_hold);
    chk("err_cnt", FW'(bus.frame_err_cnt), FW'(m_err));
  endtask

  task automatic send_frame(input logic [FW-1:0] f, input logic r);
    for (int i = 0; i < NS; i++) step(1'b1, i == 0, f[SW*i +: SW], r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_out_vld", FW'(bus.out_vld), '0);
    chk("rst_out_dat", bus.out_dat, '0);
    chk("rst_in_rdy", FW'(bus.in_rdy), FW'(1));
    chk("rst_err", FW'(bus.frame_err_cnt), '0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [FW-1:0] inc_frame(input int base);
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < NS; i++) f[SW*i +: SW] = SW'(base + i);
    return f;
  endfunction

  initial begin
    logic [FW-1:0] f1, f2;
    logic          s;
    n_cmp = 0;
    n_bad = 0;
    bus.in_vld = 1'b0; bus.in_sof = 1'b0; bus.in_dat = '0; bus.out_rdy = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Incrementing frame, consumer always ready
    f1 = inc_frame(1);
    send_frame(f1, 1'b1);
    chk("t1_vld", FW'(bus.out_vld), FW'(1));
    chk("t1_word", bus.out_dat, f1);
    chk("t1_s0", FW'(bus.out_dat[SW-1:0]), FW'(1));
    chk("t1_s47", FW'(bus.out_dat[SW*47 +: SW]), FW'(48));
    chk("t1_err", FW'(bus.frame_err_cnt), '0);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("t1_vld_once", FW'(bus.out_vld), '0);

    // All-zero frame
    send_frame('0, 1'b1);
    chk("t2_zero", bus.out_dat, '0);
    chk("t2_vld", FW'(bus.out_vld), FW'(1));
    step(1'b0, 1'b0, '0, 1'b1);

    // Two frames under backpressure
    f1 = inc_frame(100);
    f2 = inc_frame(2000);
    send_frame(f1, 1'b0);
    for (int i = 0; i < NS - 1; i++) step(1'b1, i == 0, f2[SW*i +: SW], 1'b0);
    chk("t3_stall", FW'(bus.in_rdy), '0);
    chk("t3_hold", bus.out_dat, f1);
    repeat (3) step(1'b1, 1'b0, f2[SW*47 +: SW], 1'b0);
    chk("t3_hold2", bus.out_dat, f1);
    step(1'b1, 1'b0, f2[SW*47 +: SW], 1'b1);
    chk("t3_drained", FW'(bus.out_vld), '0);
    chk("t3_rdy_back", FW'(bus.in_rdy), FW'(1));
    step(1'b1, 1'b0, f2[SW*47 +: SW], 1'b0);
    chk("t3_f2_vld", FW'(bus.out_vld), FW'(1));
    chk("t3_f2", bus.out_dat, f2);
    step(1'b0, 1'b0, '0, 1'b1);

    // Truncation by sof at idx=10
    do_reset();
    f1 = inc_frame(500);
    for (int i = 0; i < 10; i++) step(1'b1, i == 0, SW'(9000 + i), 1'b1);
    send_frame(f1, 1'b1);
    chk("t4_err", FW'(bus.frame_err_cnt), FW'(1));
    chk("t4_word", bus.out_dat, f1);
    step(1'b0, 1'b0, '0, 1'b1);

    // Orphans and saturation
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, SW'(i), 1'b1);
    chk("t5_err3", FW'(bus.frame_err_cnt), FW'(3));
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0, SW'($urandom), 1'b1);
    chk("t5_err255", FW'(bus.frame_err_cnt), FW'(255));
    chk("t5_novld", FW'(bus.out_vld), '0);

    // Asynchronous reset mid-frame while a frame is held
    do_reset();
    send_frame(inc_frame(7), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, i == 0, SW'(i), 1'b0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("t6_vld_async", FW'(bus.out_vld), '0);
    chk("t6_dat_async", bus.out_dat, '0);
    chk("t6_err_async", FW'(bus.frame_err_cnt), '0);
    chk("t6_rdy_async", FW'(bus.in_rdy), FW'(1));
    @(negedge clk);
    rst = 1'b1;
    f1 = inc_frame(300);
    send_frame(f1, 1'b1);
    chk("t6_word", bus.out_dat, f1);
    chk("t6_vld", FW'(bus.out_vld), FW'(1));

    // Random traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (part.size() == 0) s = ($urandom_range(0, 3) == 0);
      else                  s = ($urandom_range(0, 79) == 0);
      step($urandom_range(0, 3) != 0, s, SW'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
